// File: rtl/tail_light_pkg.sv
// Shared types and defaults for the tail-light controller: FSM state
// encoding, side indices and the sequencing-side helper.
package tail_light_pkg;

    typedef enum logic [1:0] {
        TL_IDLE   = 2'd0,
        TL_LEFT   = 2'd1,
        TL_RIGHT  = 2'd2,
        TL_HAZARD = 2'd3
    } tl_state_t;

    typedef enum logic {
        LEFT_SIDE  = 1'b0,
        RIGHT_SIDE = 1'b1
    } tl_side_t;

    localparam int TL_DB_CYCLES_DEF      = 1_000_000;
    localparam int TL_TIMEOUT_CYCLES_DEF = 500_000_000;

    // Which sides run their sequence in a given state, indexed by tl_side_t.
    function automatic logic [1:0] seq_sides(input logic [1:0] st);
        logic [1:0] sides;
        sides = 2'b00;
        case (st)
            TL_LEFT:   sides[LEFT_SIDE] = 1'b1;
            TL_RIGHT:  sides[RIGHT_SIDE] = 1'b1;
            TL_HAZARD: sides = 2'b11;
            default:   sides = 2'b00;
        endcase
        return sides;
    endfunction

endpackage

// File: rtl/tail_light_ctrl_sw_debounce.sv
// Two-flop synchronizer followed by a stable-count debouncer for one raw
// driver switch. db follows the synced level after DB_CYCLES steady cycles.
module sw_debounce
    import tail_light_pkg::*;
#(
    parameter int DB_CYCLES = TL_DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic db
);

    localparam int CW = $clog2(DB_CYCLES);

    logic          sync1_q;
    logic          sync2_q;
    logic          db_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    // Any cycle where the synced level agrees with db restarts the count,
    // so a glitch shorter than DB_CYCLES never reaches db.
    always_ff @(posedge clk) begin
        if (!reset) begin
            db_q  <= 1'b0;
            cnt_q <= '0;
        end else if (sync2_q == db_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CW'(DB_CYCLES - 1)) begin
            db_q  <= sync2_q;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign db = db_q;

endmodule

// File: rtl/tail_light_ctrl.sv
// Tail-light upstream controller: debounces the four driver switches and
// resolves them in a priority FSM driving enable/clear/steady controls.
// Optional turn-signal auto-cancel: define TAIL_LIGHT_AUTOCANCEL_EN.
module tail_light_ctrl
    import tail_light_pkg::*;
#(
    parameter int DB_CYCLES      = TL_DB_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = TL_TIMEOUT_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       left_sw,
    input  logic       right_sw,
    input  logic       hazard_sw,
    input  logic       brake_sw,
    output logic       en_left,
    output logic       en_right,
    output logic       clr_left,
    output logic       clr_right,
    output logic       steady_left,
    output logic       steady_right,
    output logic [1:0] state
);

    localparam logic [1:0] S_IDLE   = TL_IDLE;
    localparam logic [1:0] S_LEFT   = TL_LEFT;
    localparam logic [1:0] S_RIGHT  = TL_RIGHT;
    localparam logic [1:0] S_HAZARD = TL_HAZARD;

    logic left_db;
    logic right_db;
    logic hazard_db;
    logic brake_db;

    sw_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_left (
        .clk   (clk),
        .reset (reset),
        .raw   (left_sw),
        .db    (left_db)
    );

    sw_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_right (
        .clk   (clk),
        .reset (reset),
        .raw   (right_sw),
        .db    (right_db)
    );

    sw_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_hazard (
        .clk   (clk),
        .reset (reset),
        .raw   (hazard_sw),
        .db    (hazard_db)
    );

    sw_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_brake (
        .clk   (clk),
        .reset (reset),
        .raw   (brake_sw),
        .db    (brake_db)
    );

    logic [1:0] state_q;
    logic [1:0] req;
    logic [1:0] next_state;
    logic [1:0] seq_next;
    logic       entering;
    logic [1:0] en_q;
    logic [1:0] clr_q;
    logic [1:0] steady_q;

    // Both turn switches together mean the same as hazard.
    always_comb begin
        req = S_IDLE;
        if (hazard_db || (left_db && right_db)) begin
            req = S_HAZARD;
        end else if (left_db) begin
            req = S_LEFT;
        end else if (right_db) begin
            req = S_RIGHT;
        end
    end

`ifdef TAIL_LIGHT_AUTOCANCEL_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    logic [TW-1:0] timer_q;
    logic          cancel_q;
    tl_side_t      cancel_side_q;
    logic          turn_state;
    logic          timeout_hit;
    logic          blocked;
    logic [1:0]    cancel_req;

    // Timeout only fires while the driver still asks for the same turn;
    // any other request moves the FSM normally and clears the timer.
    always_comb begin
        turn_state  = (state_q == S_LEFT) || (state_q == S_RIGHT);
        timeout_hit = turn_state && (req == state_q) &&
                      (timer_q == TW'(TIMEOUT_CYCLES - 1));
        cancel_req  = (cancel_side_q == LEFT_SIDE) ? S_LEFT : S_RIGHT;
        blocked     = cancel_q && (req == cancel_req);
        next_state  = (timeout_hit || blocked) ? S_IDLE : req;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            timer_q       <= '0;
            cancel_q      <= 1'b0;
            cancel_side_q <= LEFT_SIDE;
        end else begin
            if (next_state != state_q) begin
                timer_q <= '0;
            end else if (turn_state) begin
                timer_q <= timer_q + 1'b1;
            end
            // Flag holds until the cancelled request goes away.
            if (timeout_hit) begin
                cancel_q      <= 1'b1;
                cancel_side_q <= (state_q == S_LEFT) ? LEFT_SIDE : RIGHT_SIDE;
            end else if (cancel_q && (req != cancel_req)) begin
                cancel_q <= 1'b0;
            end
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT_CYCLES > 1);

    always_comb begin
        next_state = req;
    end
`endif

    always_comb begin
        seq_next = seq_sides(next_state);
        entering = (next_state != state_q);
    end

    // Entry cycle pulses clear on every sequencing side and holds enable low;
    // enable follows from the second cycle in the state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            en_q     <= 2'b00;
            clr_q    <= 2'b00;
            steady_q <= 2'b00;
        end else begin
            state_q  <= next_state;
            clr_q    <= entering ? seq_next : 2'b00;
            en_q     <= entering ? 2'b00 : seq_next;
            steady_q <= {2{brake_db}} & ~seq_next;
        end
    end

    assign en_left      = en_q[LEFT_SIDE];
    assign en_right     = en_q[RIGHT_SIDE];
    assign clr_left     = clr_q[LEFT_SIDE];
    assign clr_right    = clr_q[RIGHT_SIDE];
    assign steady_left  = steady_q[LEFT_SIDE];
    assign steady_right = steady_q[RIGHT_SIDE];
    assign state        = state_q;

endmodule

// File: tb/tb_tail_light_ctrl.sv
// Bench for tail_light_ctrl: vector table, hand sequences and random
// stimulus against a window-based behavioural model.
module tb_tail_light_ctrl;

    localparam int DB = 4;
    localparam int TO = 40;

    logic       clk;
    logic       reset;
    logic       left_sw, right_sw, hazard_sw, brake_sw;
    logic       en_left, en_right, clr_left, clr_right;
    logic       steady_left, steady_right;
    logic [1:0] state;

    int vectors;
    int miscompares;

    tail_light_ctrl #(.DB_CYCLES(DB), .TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .left_sw      (left_sw),
        .right_sw     (right_sw),
        .hazard_sw    (hazard_sw),
        .brake_sw     (brake_sw),
        .en_left      (en_left),
        .en_right     (en_right),
        .clr_left     (clr_left),
        .clr_right    (clr_right),
        .steady_left  (steady_left),
        .steady_right (steady_right),
        .state        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view: {state, en{r,l}, clr{r,l}, steady{r,l}}
    function automatic logic [7:0] pk(input logic [1:0] st, input logic [1:0] en,
                                      input logic [1:0] clr, input logic [1:0] sd);
        return {st, en, clr, sd};
    endfunction

    function automatic logic [7:0] dut_view();
        return {state, en_right, en_left, clr_right, clr_left, steady_right, steady_left};
    endfunction

    // Behavioural model. Switch bits: {brake, hazard, right, left}.
    logic [3:0] m_s1, m_s2, m_db;
    logic [3:0] m_hist [DB-1];
    logic [1:0] m_state, m_en, m_clr, m_sd;
    int         m_age;
    logic       m_cancel;
    logic [1:0] m_cstate;

    task automatic model_edge(input logic [3:0] sw, input logic rst_n);
        logic [1:0] want, nxt, seq;
        logic       flip;
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_db = '0;
            for (int j = 0; j < DB - 1; j++) m_hist[j] = '0;
            m_state = 2'd0; m_en = '0; m_clr = '0; m_sd = '0;
            m_age = 0; m_cancel = 1'b0; m_cstate = 2'd0;
            return;
        end
        if (m_db[2] || (m_db[0] && m_db[1])) want = 2'd3;
        else if (m_db[0]) want = 2'd1;
        else if (m_db[1]) want = 2'd2;
        else want = 2'd0;
        nxt = want;
`ifdef TAIL_LIGHT_AUTOCANCEL_EN
        if (m_cancel && want == m_cstate) nxt = 2'd0;
        if ((m_state == 2'd1 || m_state == 2'd2) && want == m_state && m_age == TO) begin
            nxt = 2'd0;
            m_cancel = 1'b1;
            m_cstate = m_state;
        end else if (m_cancel && want != m_cstate) begin
            m_cancel = 1'b0;
        end
`endif
        case (nxt)
            2'd1: seq = 2'b01;
            2'd2: seq = 2'b10;
            2'd3: seq = 2'b11;
            default: seq = 2'b00;
        endcase
        m_clr = (nxt != m_state) ? seq : 2'b00;
        m_en  = (nxt != m_state) ? 2'b00 : seq;
        m_sd  = {2{m_db[3]}} & ~seq;
        m_age = (nxt != m_state) ? 1 : m_age + 1;
        m_state = nxt;
        // A switch flips once its last DB synced samples all disagree with it.
        for (int i = 0; i < 4; i++) begin
            flip = (m_s2[i] != m_db[i]);
            for (int j = 0; j < DB - 1; j++)
                if (m_hist[j][i] == m_db[i]) flip = 1'b0;
            if (flip) m_db[i] = ~m_db[i];
        end
        for (int j = DB - 2; j > 0; j--) m_hist[j] = m_hist[j-1];
        m_hist[0] = m_s2;
        m_s2 = m_s1;
        m_s1 = sw;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b required %b", name, act, exp);
        end
    endtask

    task automatic step(input logic [3:0] sw, input logic rst_n);
        @(negedge clk);
        {brake_sw, hazard_sw, right_sw, left_sw} = sw;
        reset = rst_n;
        @(posedge clk);
        model_edge(sw, rst_n);
        #1;
        check("model", dut_view(), {m_state, m_en, m_clr, m_sd});
    endtask

    task automatic hold(input logic [3:0] sw, input int n);
        for (int k = 0; k < n; k++) step(sw, 1'b1);
    endtask

    typedef struct {
        logic [3:0] sw;
        int         n;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [22];

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b0;
        {brake_sw, hazard_sw, right_sw, left_sw} = 4'b0000;

        tbl[0]  = '{4'b0000, 3, pk(2'd0, 2'b00, 2'b00, 2'b00)};
        tbl[1]  = '{4'b0001, 3, pk(2'd0, 2'b00, 2'b00, 2'b00)};
        tbl[2]  = '{4'b0000, 8, pk(2'd0, 2'b00, 2'b00, 2'b00)};
        tbl[3]  = '{4'b0001, 6, pk(2'd0, 2'b00, 2'b00, 2'b00)};
        tbl[4]  = '{4'b0001, 1, pk(2'd1, 2'b00, 2'b01, 2'b00)};
        tbl[5]  = '{4'b0001, 1, pk(2'd1, 2'b01, 2'b00, 2'b00)};
        tbl[6]  = '{4'b0001, 5, pk(2'd1, 2'b01, 2'b00, 2'b00)};
        tbl[7]  = '{4'b0011, 6, pk(2'd1, 2'b01, 2'b00, 2'b00)};
        tbl[8]  = '{4'b0011, 1, pk(2'd3, 2'b00, 2'b11, 2'b00)};
        tbl[9]  = '{4'b0011, 1, pk(2'd3, 2'b11, 2'b00, 2'b00)};
        tbl[10] = '{4'b0001, 6, pk(2'd3, 2'b11, 2'b00, 2'b00)};
        tbl[11] = '{4'b0001, 1, pk(2'd1, 2'b00, 2'b01, 2'b00)};
        tbl[12] = '{4'b0001, 1, pk(2'd1, 2'b01, 2'b00, 2'b00)};
        tbl[13] = '{4'b1010, 6, pk(2'd1, 2'b01, 2'b00, 2'b00)};
        tbl[14] = '{4'b1010, 1, pk(2'd2, 2'b00, 2'b10, 2'b01)};
        tbl[15] = '{4'b1010, 1, pk(2'd2, 2'b10, 2'b00, 2'b01)};
        tbl[16] = '{4'b1110, 6, pk(2'd2, 2'b10, 2'b00, 2'b01)};
        tbl[17] = '{4'b1110, 1, pk(2'd3, 2'b00, 2'b11, 2'b00)};
        tbl[18] = '{4'b1110, 1, pk(2'd3, 2'b11, 2'b00, 2'b00)};
        tbl[19] = '{4'b1000, 6, pk(2'd3, 2'b11, 2'b00, 2'b00)};
        tbl[20] = '{4'b1000, 1, pk(2'd0, 2'b00, 2'b00, 2'b11)};
        tbl[21] = '{4'b0000, 7, pk(2'd0, 2'b00, 2'b00, 2'b00)};

        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);
        check("reset_state", dut_view(), pk(2'd0, 2'b00, 2'b00, 2'b00));

        for (int i = 0; i < 22; i++) begin
            hold(tbl[i].sw, tbl[i].n);
            check($sformatf("table[%0d]", i), dut_view(), tbl[i].exp);
        end

        // Reset in HAZARD, then re-entry with both clear pulses.
        hold(4'b0100, 7);
        check("hazard_entry", dut_view(), pk(2'd3, 2'b00, 2'b11, 2'b00));
        hold(4'b0100, 2);
        check("hazard_run", dut_view(), pk(2'd3, 2'b11, 2'b00, 2'b00));
        step(4'b0100, 1'b0);
        check("mid_reset", dut_view(), pk(2'd0, 2'b00, 2'b00, 2'b00));
        hold(4'b0100, 6);
        check("post_reset_wait", dut_view(), pk(2'd0, 2'b00, 2'b00, 2'b00));
        hold(4'b0100, 1);
        check("reentry_clear", dut_view(), pk(2'd3, 2'b00, 2'b11, 2'b00));
        hold(4'b0100, 1);
        check("reentry_run", dut_view(), pk(2'd3, 2'b11, 2'b00, 2'b00));
        hold(4'b0000, 8);

`ifdef TAIL_LIGHT_AUTOCANCEL_EN
        step(4'b0000, 1'b0);
        hold(4'b0000, 4);
        hold(4'b0001, 7);
        check("ac_entry", dut_view(), pk(2'd1, 2'b00, 2'b01, 2'b00));
        hold(4'b0001, TO - 1);
        check("ac_last_left", dut_view(), pk(2'd1, 2'b01, 2'b00, 2'b00));
        hold(4'b0001, 1);
        check("ac_cancel", dut_view(), pk(2'd0, 2'b00, 2'b00, 2'b00));
        hold(4'b0001, 20);
        check("ac_stay_idle", dut_view(), pk(2'd0, 2'b00, 2'b00, 2'b00));
        hold(4'b0000, 8);
        hold(4'b0001, 7);
        check("ac_reraise", dut_view(), pk(2'd1, 2'b00, 2'b01, 2'b00));
        hold(4'b0000, 8);
`endif

        for (int r = 0; r < 80; r++) begin
            logic [3:0] sw;
            sw = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 14) == 0) step(sw, 1'b0);
            else hold(sw, $urandom_range(1, 12));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
